csr_trap_file: RTL and testbench

//  Machine-mode CSR file with trap entry, MRET return, interrupt arbitration and

---
 rtl/csr_trap_file.sv | 209 ++++++++++++++++++++
 tb/tb_csr_trap_file.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_file.sv
// ---------------------------------------------------------------------------
// csr_trap_file
//   Machine-mode CSR file sitting beside the W stage. Holds mstatus, mie, mip,
//   mtvec, mscratch, mepc, mcause, mtval, mcycle and minstret. Takes CSR
//   writes plus retire/exception/mret events from the pipeline, arbitrates
//   machine interrupts, and produces a same-cycle PC redirect (trap vector or
//   mepc) for pcselect.
//
// Ports
//   i_clk            clock
//   i_resetn         synchronous active-low reset
//   i_ra / o_rd      CSR read address / combinational read data
//   i_we, i_wa, i_wd CSR write strobe, address, data
//   i_retire         one instruction retired this cycle (minstret)
//   i_is_mret        MRET committing this cycle
//   i_exc_valid      synchronous exception at commit
//   i_exc_code       exception cause code
//   i_exc_pc         PC of the faulting / interrupted instruction
//   i_exc_tval       mtval value for an exception
//   i_irq_ok         pipeline can take an interrupt at i_exc_pc this cycle
//   i_irq_msi/mti/mei  machine software / timer / external interrupt levels
//   o_redirect_valid flush the pipeline and fetch from o_redirect_pc
//   o_redirect_pc    trap vector or mepc
//   o_mepc           current mepc
// ---------------------------------------------------------------------------
module csr_trap_file #(
   parameter int             XLEN        = 64,
   parameter bit             VECTORED_EN = 1'b1,
   parameter logic [XLEN-1:0] MEPC_RST   = 'h8000_0000
) (
   input  logic            i_clk,
   input  logic            i_resetn,
   input  logic [11:0]     i_ra,
   output logic [XLEN-1:0] o_rd,
   input  logic            i_we,
   input  logic [11:0]     i_wa,
   input  logic [XLEN-1:0] i_wd,
   input  logic            i_retire,
   input  logic            i_is_mret,
   input  logic            i_exc_valid,
   input  logic [4:0]      i_exc_code,
   input  logic [XLEN-1:0] i_exc_pc,
   input  logic [XLEN-1:0] i_exc_tval,
   input  logic            i_irq_ok,
   input  logic            i_irq_msi,
   input  logic            i_irq_mti,
   input  logic            i_irq_mei,
   output logic            o_redirect_valid,
   output logic [XLEN-1:0] o_redirect_pc,
   output logic [XLEN-1:0] o_mepc
);

   localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
   localparam logic [11:0] ADDR_MIE      = 12'h304;
   localparam logic [11:0] ADDR_MTVEC    = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
   localparam logic [11:0] ADDR_MEPC     = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
   localparam logic [11:0] ADDR_MTVAL    = 12'h343;
   localparam logic [11:0] ADDR_MIP      = 12'h344;
   localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
   localparam logic [11:0] ADDR_MINSTRET = 12'hB02;

   // mstatus field positions
   localparam int MIE_BIT  = 3;
   localparam int MPIE_BIT = 7;

   // mstatus is stored without its top bit: sd is derived from fs/xs
   logic [XLEN-2:0] r_mstatus;
   logic [XLEN-1:0] r_mie;
   logic [XLEN-1:0] r_mtvec;
   logic [XLEN-1:0] r_mscratch;
   logic [XLEN-1:0] r_mepc;
   logic [XLEN-1:0] r_mcause;
   logic [XLEN-1:0] r_mtval;
   logic [XLEN-1:0] r_mcycle;
   logic [XLEN-1:0] r_minstret;
   // sampled interrupt levels {mei, mti, msi}
   logic [2:0]      r_mip;

   logic            w_sd;
   logic [XLEN-1:0] w_mipView;
   logic            w_ipMei;
   logic            w_ipMsi;
   logic            w_ipMti;
   logic            w_takeIrq;
   logic            w_trap;
   logic [4:0]      w_irqCode;
   logic [XLEN-1:0] w_cause;
   logic [XLEN-1:0] w_trapBase;
   logic [XLEN-1:0] w_trapPc;
   logic            w_useVector;

   assign w_sd = (r_mstatus[14:13] == 2'b11) | (r_mstatus[16:15] == 2'b11);

   // mip as seen by software: only the three sampled levels exist
   always_comb begin
      w_mipView     = '0;
      w_mipView[3]  = r_mip[0];
      w_mipView[7]  = r_mip[1];
      w_mipView[11] = r_mip[2];
   end

   assign w_ipMei = r_mie[11] & r_mip[2];
   assign w_ipMsi = r_mie[3]  & r_mip[0];
   assign w_ipMti = r_mie[7]  & r_mip[1];

   // An exception at commit always pre-empts an interrupt in the same cycle
   assign w_takeIrq = r_mstatus[MIE_BIT] & (w_ipMei | w_ipMsi | w_ipMti)
                      & i_irq_ok & ~i_exc_valid;
   assign w_trap    = i_exc_valid | w_takeIrq;

   // Interrupt priority: external, then software, then timer
   always_comb begin
      w_irqCode = 5'd7;
      if (w_ipMei)
         w_irqCode = 5'd11;
      else if (w_ipMsi)
         w_irqCode = 5'd3;
   end

   assign w_cause = i_exc_valid ? {{(XLEN-5){1'b0}}, i_exc_code}
                                : {1'b1, {(XLEN-6){1'b0}}, w_irqCode};

   // Vectored mode only applies to interrupts; exceptions go to the base
   assign w_trapBase  = {r_mtvec[XLEN-1:2], 2'b00};
   assign w_useVector = VECTORED_EN && (r_mtvec[1:0] == 2'b01) && !i_exc_valid;
   assign w_trapPc    = w_useVector
                        ? w_trapBase + {{(XLEN-7){1'b0}}, w_irqCode, 2'b00}
                        : w_trapBase;

   // Redirect is computed from the registers as they stand before this
   // cycle's update, and is suppressed while reset is asserted
   assign o_redirect_valid = i_resetn & (w_trap | i_is_mret);
   assign o_redirect_pc    = w_trap ? w_trapPc : r_mepc;
   assign o_mepc           = r_mepc;

   // Combinational CSR read port; unknown addresses read as zero
   always_comb begin
      o_rd = '0;
      case (i_ra)
         ADDR_MSTATUS:  o_rd = {w_sd, r_mstatus};
         ADDR_MIE:      o_rd = r_mie;
         ADDR_MTVEC:    o_rd = r_mtvec;
         ADDR_MSCRATCH: o_rd = r_mscratch;
         ADDR_MEPC:     o_rd = r_mepc;
         ADDR_MCAUSE:   o_rd = r_mcause;
         ADDR_MTVAL:    o_rd = r_mtval;
         ADDR_MIP:      o_rd = w_mipView;
         ADDR_MCYCLE:   o_rd = r_mcycle;
         ADDR_MINSTRET: o_rd = r_minstret;
         default:       o_rd = '0;
      endcase
   end

   // CSR state update. Later assignments in this block deliberately override
   // earlier ones: a counter write overrides the increment, and MRET's
   // mstatus fields override a simultaneous mstatus write. A trap drops any
   // CSR write in the same cycle.
   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_mstatus  <= '0;
         r_mie      <= '0;
         r_mtvec    <= '0;
         r_mscratch <= '0;
         r_mepc     <= MEPC_RST;
         r_mcause   <= XLEN'(2);
         r_mtval    <= '0;
         r_mcycle   <= '0;
         r_minstret <= '0;
         r_mip      <= '0;
      end else begin
         r_mip    <= {i_irq_mei, i_irq_mti, i_irq_msi};
         r_mcycle <= r_mcycle + 1'b1;
         if (i_retire)
            r_minstret <= r_minstret + 1'b1;

         if (w_trap) begin
            r_mepc                <= {i_exc_pc[XLEN-1:2], 2'b00};
            r_mcause              <= w_cause;
            r_mtval               <= i_exc_valid ? i_exc_tval : '0;
            r_mstatus[MPIE_BIT]   <= r_mstatus[MIE_BIT];
            r_mstatus[MIE_BIT]    <= 1'b0;
            r_mstatus[12:11]      <= 2'b11;
         end else begin
            if (i_we) begin
               case (i_wa)
                  ADDR_MSTATUS:  r_mstatus  <= i_wd[XLEN-2:0];
                  ADDR_MIE:      r_mie      <= i_wd;
                  ADDR_MTVEC:    r_mtvec    <= i_wd;
                  ADDR_MSCRATCH: r_mscratch <= i_wd;
                  ADDR_MEPC:     r_mepc     <= {i_wd[XLEN-1:2], 2'b00};
                  ADDR_MCAUSE:   r_mcause   <= i_wd;
                  ADDR_MTVAL:    r_mtval    <= i_wd;
                  ADDR_MCYCLE:   r_mcycle   <= i_wd;
                  ADDR_MINSTRET: r_minstret <= i_wd;
                  default:       ;
               endcase
            end
            if (i_is_mret) begin
               r_mstatus[MIE_BIT]  <= r_mstatus[MPIE_BIT];
               r_mstatus[MPIE_BIT] <= 1'b1;
               r_mstatus[12:11]    <= 2'b00;
            end
         end
      end
   end

endmodule

// File: tb/tb_csr_trap_file.sv
// ---------------------------------------------------------------------------
// tb_csr_trap_file
//   Self-checking bench for csr_trap_file (XLEN=64, vectored mode on).
//   Each scenario task drives stimulus, checks the combinational redirect
//   directly, and pushes the CSR values it expects afterwards onto a
//   scoreboard queue that is drained through the read port once the DUT
//   has updated.
// ---------------------------------------------------------------------------
module tb_csr_trap_file;

   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MIE      = 12'h304;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MTVAL    = 12'h343;
   localparam logic [11:0] A_MIP      = 12'h344;
   localparam logic [11:0] A_MCYCLE   = 12'hB00;
   localparam logic [11:0] A_MINSTRET = 12'hB02;
   localparam logic [63:0] MEPC_RST   = 64'h8000_0000;

   typedef struct {
      string       name;
      logic [11:0] addr;
      logic [63:0] val;
   } exp_t;

   logic        clk;
   logic        resetn;
   logic [11:0] ra;
   logic [63:0] rd;
   logic        we;
   logic [11:0] wa;
   logic [63:0] wd;
   logic        retire;
   logic        isMret;
   logic        excValid;
   logic [4:0]  excCode;
   logic [63:0] excPc;
   logic [63:0] excTval;
   logic        irqOk;
   logic        irqMsi;
   logic        irqMti;
   logic        irqMei;
   logic        redirectValid;
   logic [63:0] redirectPc;
   logic [63:0] mepcOut;

   exp_t sbQ[$];
   int   errors = 0;
   int   checks = 0;

   csr_trap_file #(
      .XLEN(64),
      .VECTORED_EN(1'b1),
      .MEPC_RST(MEPC_RST)
   ) dut (
      .i_clk(clk),
      .i_resetn(resetn),
      .i_ra(ra),
      .o_rd(rd),
      .i_we(we),
      .i_wa(wa),
      .i_wd(wd),
      .i_retire(retire),
      .i_is_mret(isMret),
      .i_exc_valid(excValid),
      .i_exc_code(excCode),
      .i_exc_pc(excPc),
      .i_exc_tval(excTval),
      .i_irq_ok(irqOk),
      .i_irq_msi(irqMsi),
      .i_irq_mti(irqMti),
      .i_irq_mei(irqMei),
      .o_redirect_valid(redirectValid),
      .o_redirect_pc(redirectPc),
      .o_mepc(mepcOut)
   );

   // Slow clock so several scoreboard reads fit inside one low phase
   initial clk = 1'b0;
   always #20 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Record a CSR value expected once the DUT has updated
   task automatic expectCsr(input string name, input logic [11:0] a, input logic [63:0] v);
      exp_t e;
      e.name = name;
      e.addr = a;
      e.val  = v;
      sbQ.push_back(e);
   endtask

   // Return every pipeline input to idle
   task automatic applyStimulus();
      we = 1'b0; wa = '0; wd = '0; retire = 1'b0; isMret = 1'b0;
      excValid = 1'b0; excCode = '0; excPc = '0; excTval = '0;
      irqOk = 1'b0; irqMsi = 1'b0; irqMti = 1'b0; irqMei = 1'b0;
   endtask

   // One-cycle CSR write; returns at the negedge after the write has landed
   task automatic csrWrite(input logic [11:0] a, input logic [63:0] d);
      @(negedge clk);
      we = 1'b1; wa = a; wd = d;
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      resetn = 1'b0;
      ra = '0;
      applyStimulus();
      excValid = 1'b1; excCode = 5'd4; excPc = 64'h1234; excTval = 64'h77;
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (redirectValid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_redirect: got %0b expected 0", redirectValid);
      end
      expectCsr("rst_mepc", A_MEPC, MEPC_RST);
      expectCsr("rst_mcause", A_MCAUSE, 64'd2);
      expectCsr("rst_mtval", A_MTVAL, 64'd0);
      expectCsr("rst_mstatus", A_MSTATUS, 64'd0);
      expectCsr("rst_mcycle", A_MCYCLE, 64'd0);
      while (sbQ.size() > 0) begin
         e = sbQ.pop_front();
         ra = e.addr; #1;
         checks++;
         if (rd !== e.val) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", e.name, rd, e.val);
         end
      end
      @(negedge clk);
      resetn = 1'b1;
      applyStimulus();
      @(negedge clk);
      expectCsr("rel_mcycle", A_MCYCLE, 64'd1);
      expectCsr("rel_minstret", A_MINSTRET, 64'd0);
      expectCsr("rel_mepc", A_MEPC, MEPC_RST);
      expectCsr("rel_mcause", A_MCAUSE, 64'd2);
      while (sbQ.size() > 0) begin
         e = sbQ.pop_front();
         ra = e.addr; #1;
         checks++;
         if (rd !== e.val) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", e.name, rd, e.val);
         end
      end
      checks++;
      if (mepcOut !== MEPC_RST) begin
         errors++;
         $display("[TB] FAIL rel_mepc_port: got %h expected %h", mepcOut, MEPC_RST);
      end
   endtask

   task automatic test_misc();
      exp_t e;
      csrWrite(12'h7C0, 64'h1234);
      csrWrite(A_MSCRATCH, 64'hCAFE_F00D);
      csrWrite(A_MIP, 64'hFFFF);
      csrWrite(A_MEPC, 64'h4000_0007);
      expectCsr("unknown_addr", 12'h7C0, 64'd0);
      expectCsr("mscratch", A_MSCRATCH, 64'hCAFE_F00D);
      expectCsr("mip_readonly", A_MIP, 64'd0);
      expectCsr("mepc_align", A_MEPC, 64'h4000_0004);
      while (sbQ.size() > 0) begin
         e = sbQ.pop_front();
         ra = e.addr; #1;
         checks++;
         if (rd !== e.val) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", e.name, rd, e.val);
         end
      end
   endtask

   task automatic test_exception();
      exp_t e;
      csrWrite(A_MTVEC, 64'h100);
      excValid = 1'b1; excCode = 5'd2; excPc = 64'h8000_0010; excTval = 64'hDEAD;
      #1;
      checks++;
      if (redirectValid !== 1'b1 || redirectPc !== 64'h100) begin
         errors++;
         $display("[TB] FAIL exc_redirect: got v=%0b pc=%h expected v=1 pc=%h",
                  redirectValid, redirectPc, 64'h100);
      end
      expectCsr("exc_mepc", A_MEPC, 64'h8000_0010);
      expectCsr("exc_mcause", A_MCAUSE, 64'd2);
      expectCsr("exc_mtval", A_MTVAL, 64'hDEAD);
      expectCsr("exc_mstatus", A_MSTATUS, 64'h1800);
      @(negedge clk);
      applyStimulus();
      while (sbQ.size() > 0) begin
         e = sbQ.pop_front();
         ra = e.addr; #1;
         checks++;
         if (rd !== e.val) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", e.name, rd, e.val);
         end
      end
   endtask

   task automatic test_irq_vectored();
      exp_t e;
      csrWrite(A_MSTATUS, 64'h8);
      csrWrite(A_MIE, 64'h80);
      csrWrite(A_MTVEC, 64'h201);
      irqMti = 1'b1; irqOk = 1'b1; excPc = 64'h8000_0046; excTval = 64'h55;
      #1;
      checks++;
      if (redirectValid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL irq_before_sample: got %0b expected 0", redirectValid);
      end
      @(negedge clk);
      #1;
      checks++;
      if (redirectValid !== 1'b1 || redirectPc !== 64'h21C) begin
         errors++;
         $display("[TB] FAIL irq_redirect: got v=%0b pc=%h expected v=1 pc=%h",
                  redirectValid, redirectPc, 64'h21C);
      end
      expectCsr("irq_mcause", A_MCAUSE, 64'h8000_0000_0000_0007);
      expectCsr("irq_mepc", A_MEPC, 64'h8000_0044);
      expectCsr("irq_mtval", A_MTVAL, 64'd0);
      expectCsr("irq_mstatus", A_MSTATUS, 64'h1880);
      expectCsr("irq_mip", A_MIP, 64'h80);
      @(negedge clk);
      applyStimulus();
      while (sbQ.size() > 0) begin
         e = sbQ.pop_front();
         ra = e.addr; #1;
         checks++;
         if (rd !== e.val) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", e.name, rd, e.val);
         end
      end
   endtask

   task automatic test_irq_priority();
      exp_t        e;
      logic [2:0]  pat [3];
      int          code [3];
      logic [63:0] expPc;
      pat[0] = 3'b111; code[0] = 11;
      pat[1] = 3'b011; code[1] = 3;
      pat[2] = 3'b001; code[2] = 7;
      csrWrite(A_MIE, 64'h888);
      for (int i = 0; i < 3; i++) begin
         csrWrite(A_MSTATUS, 64'h8);
         irqMei = pat[i][2]; irqMsi = pat[i][1]; irqMti = pat[i][0];
         irqOk = 1'b0; excPc = 64'h8000_0300;
         @(negedge clk);
         irqOk = 1'b1;
         #1;
         expPc = 64'h200 + 64'(code[i] * 4);
         checks++;
         if (redirectValid !== 1'b1 || redirectPc !== expPc) begin
            errors++;
            $display("[TB] FAIL prio_redirect_%0d: got v=%0b pc=%h expected v=1 pc=%h",
                     i, redirectValid, redirectPc, expPc);
         end
         expectCsr($sformatf("prio_mcause_%0d", i), A_MCAUSE,
                   {1'b1, 58'd0, 5'(code[i])});
         @(negedge clk);
         applyStimulus();
         while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            ra = e.addr; #1;
            checks++;
            if (rd !== e.val) begin
               errors++;
               $display("[TB] FAIL %s: got %h expected %h", e.name, rd, e.val);
            end
         end
      end
   endtask

   task automatic test_exc_over_irq();
      exp_t e;
      csrWrite(A_MSTATUS, 64'h8);
      irqMti = 1'b1; irqOk = 1'b0;
      @(negedge clk);
      irqOk = 1'b1;
      excValid = 1'b1; excCode = 5'd5; excPc = 64'h8000_0100; excTval = 64'hBEEF;
      #1;
      checks++;
      if (redirectValid !== 1'b1 || redirectPc !== 64'h200) begin
         errors++;
         $display("[TB] FAIL excirq_redirect: got v=%0b pc=%h expected v=1 pc=%h",
                  redirectValid, redirectPc, 64'h200);
      end
      expectCsr("excirq_mcause", A_MCAUSE, 64'd5);
      expectCsr("excirq_mtval", A_MTVAL, 64'hBEEF);
      expectCsr("excirq_mepc", A_MEPC, 64'h8000_0100);
      expectCsr("excirq_mstatus", A_MSTATUS, 64'h1880);
      @(negedge clk);
      applyStimulus();
      while (sbQ.size() > 0) begin
         e = sbQ.pop_front();
         ra = e.addr; #1;
         checks++;
         if (rd !== e.val) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", e.name, rd, e.val);
         end
      end
   endtask

   task automatic test_mret();
      exp_t e;
      csrWrite(A_MSTATUS, 64'h80);
      csrWrite(A_MEPC, 64'h8000_1236);
      isMret = 1'b1;
      #1;
      checks++;
      if (redirectValid !== 1'b1 || redirectPc !== 64'h8000_1234) begin
         errors++;
         $display("[TB] FAIL mret_redirect: got v=%0b pc=%h expected v=1 pc=%h",
                  redirectValid, redirectPc, 64'h8000_1234);
      end
      expectCsr("mret_mstatus", A_MSTATUS, 64'h88);
      expectCsr("mret_mepc", A_MEPC, 64'h8000_1234);
      @(negedge clk);
      applyStimulus();
      while (sbQ.size() > 0) begin
         e = sbQ.pop_front();
         ra = e.addr; #1;
         checks++;
         if (rd !== e.val) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", e.name, rd, e.val);
         end
      end
      // MRET together with an mstatus write: written fs field stays, mret fields win
      @(negedge clk);
      isMret = 1'b1; we = 1'b1; wa = A_MSTATUS; wd = 64'h6000;
      expectCsr("mretwr_mstatus", A_MSTATUS, 64'h8000_0000_0000_6088);
      @(negedge clk);
      applyStimulus();
      while (sbQ.size() > 0) begin
         e = sbQ.pop_front();
         ra = e.addr; #1;
         checks++;
         if (rd !== e.val) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", e.name, rd, e.val);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      @(negedge clk);
      excValid = 1'b1; excCode = 5'd7; excPc = 64'h8000_2000; excTval = 64'h1;
      we = 1'b1; wa = A_MSCRATCH; wd = 64'h1111;
      #1;
      checks++;
      if (redirectValid !== 1'b1 || redirectPc !== 64'h200) begin
         errors++;
         $display("[TB] FAIL b2b_exc_redirect: got v=%0b pc=%h expected v=1 pc=%h",
                  redirectValid, redirectPc, 64'h200);
      end
      @(negedge clk);
      applyStimulus();
      isMret = 1'b1;
      #1;
      checks++;
      if (redirectValid !== 1'b1 || redirectPc !== 64'h8000_2000) begin
         errors++;
         $display("[TB] FAIL b2b_mret_redirect: got v=%0b pc=%h expected v=1 pc=%h",
                  redirectValid, redirectPc, 64'h8000_2000);
      end
      expectCsr("b2b_mstatus", A_MSTATUS, 64'h8000_0000_0000_6088);
      expectCsr("b2b_mcause", A_MCAUSE, 64'd7);
      expectCsr("b2b_mtval", A_MTVAL, 64'h1);
      expectCsr("b2b_mepc", A_MEPC, 64'h8000_2000);
      expectCsr("b2b_mscratch_dropped", A_MSCRATCH, 64'hCAFE_F00D);
      @(negedge clk);
      applyStimulus();
      while (sbQ.size() > 0) begin
         e = sbQ.pop_front();
         ra = e.addr; #1;
         checks++;
         if (rd !== e.val) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", e.name, rd, e.val);
         end
      end
   endtask

   task automatic test_counters();
      exp_t e;
      csrWrite(A_MINSTRET, 64'd10);
      we = 1'b1; wa = A_MCYCLE; wd = '1; retire = 1'b1;
      @(negedge clk);
      applyStimulus();
      expectCsr("cnt_write_wins", A_MCYCLE, 64'hFFFF_FFFF_FFFF_FFFF);
      expectCsr("cnt_minstret", A_MINSTRET, 64'd11);
      while (sbQ.size() > 0) begin
         e = sbQ.pop_front();
         ra = e.addr; #1;
         checks++;
         if (rd !== e.val) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", e.name, rd, e.val);
         end
      end
      @(negedge clk);
      expectCsr("cnt_wrap", A_MCYCLE, 64'd0);
      expectCsr("cnt_minstret_hold", A_MINSTRET, 64'd11);
      while (sbQ.size() > 0) begin
         e = sbQ.pop_front();
         ra = e.addr; #1;
         checks++;
         if (rd !== e.val) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", e.name, rd, e.val);
         end
      end
   endtask

   // Scenarios run in order; each builds on the CSR state left by the last
   initial begin
      test_reset();
      test_misc();
      test_exception();
      test_irq_vectored();
      test_irq_priority();
      test_exc_over_irq();
      test_mret();
      test_back_to_back();
      test_counters();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
